vga_timing_gen: RTL and testbench

//  Raster timing source for the 640x480@60 display path, clocked by the 25 MHz vga_clk.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the coordinate type shared with the renderers.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [9:0] coord_t;

  // Truncates an integer timing value to the 10-bit coordinate domain.
  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Asynchronously reset shift register used to align sync outputs with registered colour data.
module sync_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      assign stage_d[0] = din;
      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        assign stage_d[gi] = stage_q[gi-1];
      end

      // Every stage clears on reset so no partial sync pulse leaks out afterwards.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q <= {DEPTH{RESET_VAL}};
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counter with visible/line/frame decodes, frame counter and delayed syncs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam coord_t H_LAST  = to_coord(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST  = to_coord(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS   = to_coord(H_VISIBLE);
  localparam coord_t V_VIS   = to_coord(V_VISIBLE);
  localparam coord_t HS_ON   = to_coord(H_VISIBLE + H_FRONT);
  localparam coord_t HS_OFF  = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_ON   = to_coord(V_VISIBLE + V_FRONT);
  localparam coord_t VS_OFF  = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t     drawx_q, drawx_d;
  coord_t     drawy_q, drawy_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       hs_raw, vs_raw;

  always_comb begin
    drawx_d       = drawx_q + 10'd1;
    drawy_d       = drawy_q;
    frame_count_d = frame_count_q;
    if (drawx_q == H_LAST) begin
      drawx_d = '0;
      if (drawy_q == V_LAST) begin
        drawy_d       = '0;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        drawy_d = drawy_q + 10'd1;
      end
    end
  end

  // Reset parks the raster on the last pixel so the first clock wraps into frame 0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      drawx_q       <= H_LAST;
      drawy_q       <= V_LAST;
      frame_count_q <= 8'hFF;
    end else begin
      drawx_q       <= drawx_d;
      drawy_q       <= drawy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign frame_count = frame_count_q;
  assign blank       = (drawx_q < H_VIS) && (drawy_q < V_VIS);
  assign line_start  = (drawx_q == '0);
  assign frame_start = (drawx_q == '0) && (drawy_q == '0);

  // vs is a whole-line decode; it is not aligned to the hsync edge.
  assign hs_raw = ((drawx_q >= HS_ON) && (drawx_q < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((drawy_q >= VS_ON) && (drawy_q < VS_OFF)) ? SYNC_POL : ~SYNC_POL;

  sync_delay_line #(
    .WIDTH    (2),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL({~SYNC_POL, ~SYNC_POL})
  ) u_sync_delay (
    .clk (vga_clk),
    .rst (reset),
    .din ({hs_raw, vs_raw}),
    .dout({hs, vs})
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster at pipe delays 1/0/3 plus a shrunken raster for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  logic [9:0] m_x, m_y, z_x, z_y, t_x, t_y, s_x, s_y;
  logic       m_blank, m_hs, m_vs, m_ls, m_fs;
  logic       z_blank, z_hs, z_vs, z_ls, z_fs;
  logic       t_blank, t_hs, t_vs, t_ls, t_fs;
  logic       s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] m_fc, z_fc, t_fc, s_fc;

  vga_timing_gen dut_main (
    .vga_clk(clk), .reset(rst), .DrawX(m_x), .DrawY(m_y), .blank(m_blank), .hs(m_hs), .vs(m_vs),
    .line_start(m_ls), .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen #(.PIPE_DELAY(0)) dut_p0 (
    .vga_clk(clk), .reset(rst), .DrawX(z_x), .DrawY(z_y), .blank(z_blank), .hs(z_hs), .vs(z_vs),
    .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

  vga_timing_gen #(.PIPE_DELAY(3)) dut_p3 (
    .vga_clk(clk), .reset(rst), .DrawX(t_x), .DrawY(t_y), .blank(t_blank), .hs(t_hs), .vs(t_vs),
    .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc));

  // 8x5 raster: 40 clocks per frame, hs raw at X=5..6, vs raw at Y=3.
  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_small (
    .vga_clk(clk), .reset(rst), .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

  int errors = 0;
  int checks = 0;
  int k = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int k;
    int x;
    int y;
    int blank;
    int hs;
    int ls;
    int fs;
    int fc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic apply_vec(input int vi);
    $display("vec %0d k=%0d X=%0d Y=%0d blank=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
             vi, k, m_x, m_y, m_blank, m_hs, m_vs, m_ls, m_fs, m_fc);
    check("vec_x",     int'(m_x),     vecs[vi].x);
    check("vec_y",     int'(m_y),     vecs[vi].y);
    check("vec_blank", int'(m_blank), vecs[vi].blank);
    check("vec_hs",    int'(m_hs),    vecs[vi].hs);
    check("vec_vs",    int'(m_vs),    1);
    check("vec_ls",    int'(m_ls),    vecs[vi].ls);
    check("vec_fs",    int'(m_fs),    vecs[vi].fs);
    check("vec_fc",    int'(m_fc),    vecs[vi].fc);
  endtask

  // Statistics gathered during the long first run.
  int m_blank_cnt = 0, m_hs_low_cnt = 0, m_hs_fall = 0, m_hs_rise = 0;
  int z_hs_fall = 0, z_hs_rise = 0, t_hs_fall = 0, t_hs_rise = 0;
  int ls_cnt = 0, ls_last = 0, ls_bad = 0, inst_bad = 0;
  int s_vs_low = 0, s_vs_fall = 0, s_blank_cnt = 0;
  int s_fs_cnt = 0, s_fs_last = 0, s_fs_bad = 0;
  int s_fc_41 = -1, s_fc_81 = -1, s_fc_10240 = -1, s_fc_10241 = -1;
  int s_fs_10240 = -1, s_fs_10241 = -1, s_fs_10242 = -1;

  task automatic run_cycles(input int n, input bit stats);
    int vi;
    logic pm, pz, pt, ps;
    vi = 0;
    pm = 1'b1; pz = 1'b1; pt = 1'b1; ps = 1'b1;
    for (int c = 0; c < n; c++) begin
      step();
      while (vi < NVEC && vecs[vi].k == k) begin
        apply_vec(vi);
        vi++;
      end
      if (stats) begin
        if (k <= 800) begin
          if (m_blank) m_blank_cnt++;
          if (!m_hs) m_hs_low_cnt++;
          if (pm && !m_hs && m_hs_fall == 0) m_hs_fall = k;
          if (!pm && m_hs && m_hs_rise == 0) m_hs_rise = k;
          if (pz && !z_hs && z_hs_fall == 0) z_hs_fall = k;
          if (!pz && z_hs && z_hs_rise == 0) z_hs_rise = k;
          if (pt && !t_hs && t_hs_fall == 0) t_hs_fall = k;
          if (!pt && t_hs && t_hs_rise == 0) t_hs_rise = k;
        end
        if (m_ls) begin
          if (ls_cnt > 0 && k - ls_last != 800) ls_bad++;
          ls_cnt++;
          ls_last = k;
        end
        if (z_x != m_x || t_x != m_x || z_y != m_y || t_y != m_y ||
            z_blank != m_blank || t_blank != m_blank) inst_bad++;
        if (k <= 40) begin
          if (!s_vs) s_vs_low++;
          if (s_blank) s_blank_cnt++;
          if (ps && !s_vs && s_vs_fall == 0) s_vs_fall = k;
        end
        if (s_fs) begin
          if (s_fs_cnt > 0 && k - s_fs_last != 40) s_fs_bad++;
          s_fs_cnt++;
          s_fs_last = k;
        end
        if (k == 41)    s_fc_41 = s_fc;
        if (k == 81)    s_fc_81 = s_fc;
        if (k == 10240) begin s_fc_10240 = s_fc; s_fs_10240 = s_fs; end
        if (k == 10241) begin s_fc_10241 = s_fc; s_fs_10241 = s_fs; end
        if (k == 10242) s_fs_10242 = s_fs;
      end
      pm = m_hs; pz = z_hs; pt = t_hs; ps = s_vs;
    end
  endtask

  task automatic check_reset_state(input string tag);
    $display("%s: X=%0d Y=%0d blank=%0d hs=%0d vs=%0d fc=%0d", tag, m_x, m_y, m_blank, m_hs, m_vs, m_fc);
    check({tag, "_x"},     int'(m_x),     799);
    check({tag, "_y"},     int'(m_y),     524);
    check({tag, "_blank"}, int'(m_blank), 0);
    check({tag, "_hs"},    int'(m_hs),    1);
    check({tag, "_vs"},    int'(m_vs),    1);
    check({tag, "_ls"},    int'(m_ls),    0);
    check({tag, "_fs"},    int'(m_fs),    0);
    check({tag, "_fc"},    int'(m_fc),    255);
    check({tag, "_p3_hs"}, int'(t_hs),    1);
    check({tag, "_p0_hs"}, int'(z_hs),    1);
    check({tag, "_s_xy"},  int'({s_x, s_y}), int'({10'd7, 10'd4}));
    check({tag, "_s_fc"},  int'(s_fc),    255);
  endtask

  initial begin
    //            k     X    Y  blank hs ls fs fc
    vecs[0]  = '{1,     0,   0, 1,    1, 1, 1, 0};
    vecs[1]  = '{2,     1,   0, 1,    1, 0, 0, 0};
    vecs[2]  = '{640, 639,   0, 1,    1, 0, 0, 0};
    vecs[3]  = '{641, 640,   0, 0,    1, 0, 0, 0};
    vecs[4]  = '{657, 656,   0, 0,    1, 0, 0, 0};
    vecs[5]  = '{658, 657,   0, 0,    0, 0, 0, 0};
    vecs[6]  = '{753, 752,   0, 0,    0, 0, 0, 0};
    vecs[7]  = '{754, 753,   0, 0,    1, 0, 0, 0};
    vecs[8]  = '{800, 799,   0, 0,    1, 0, 0, 0};
    vecs[9]  = '{801,   0,   1, 1,    1, 1, 0, 0};
    vecs[10] = '{1601,  0,   2, 1,    1, 1, 0, 0};
    vecs[11] = '{1641, 40,   2, 1,    1, 0, 0, 0};

    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    run_cycles(10301, 1'b1);

    check("line_blank_clks",   m_blank_cnt, 640);
    check("line_hs_low_clks",  m_hs_low_cnt, 96);
    check("p1_hs_fall_k",      m_hs_fall, 658);
    check("p1_hs_rise_k",      m_hs_rise, 754);
    check("p0_hs_fall_k",      z_hs_fall, 657);
    check("p0_hs_rise_k",      z_hs_rise, 753);
    check("p3_hs_fall_k",      t_hs_fall, 660);
    check("p3_hs_rise_k",      t_hs_rise, 756);
    check("line_start_count",  ls_cnt, 13);
    check("line_start_period", ls_bad, 0);
    check("pipe_variants_xy",  inst_bad, 0);
    check("small_vs_low_clks", s_vs_low, 8);
    check("small_vs_fall_k",   s_vs_fall, 26);
    check("small_blank_clks",  s_blank_cnt, 8);
    check("small_fs_period",   s_fs_bad, 0);
    check("small_fs_count",    s_fs_cnt, 258);
    check("small_fc_frame1",   s_fc_41, 1);
    check("small_fc_frame2",   s_fc_81, 2);
    check("small_fc_pre_wrap", s_fc_10240, 255);
    check("small_fs_pre_wrap", s_fs_10240, 0);
    check("small_fc_wrap",     s_fc_10241, 0);
    check("small_fs_wrap",     s_fs_10241, 1);
    check("small_fs_post",     s_fs_10242, 0);

    // Main raster now sits at X=700 on line 12, inside the hsync pulse.
    $display("mid-frame: X=%0d Y=%0d hs=%0d", m_x, m_y, m_hs);
    check("mid_x",     int'(m_x),  700);
    check("mid_hs",    int'(m_hs), 0);
    rst = 1'b1;
    #1;
    check_reset_state("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("mid_hold");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    run_cycles(1641, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
